// File: rtl/datapath.sv
// Execution datapath of the 16-bit RISC CPU: eight-entry register file, A/B operand registers,
// shifter, 4-function ALU, C result register and Z/N/V status register.
module datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  readnum,
    input  logic [3:0]  vsel,
    input  logic        loada,
    input  logic        loadb,
    input  logic [1:0]  shift,
    input  logic        asel,
    input  logic        bsel,
    input  logic [1:0]  ALUop,
    input  logic        loadc,
    input  logic        loads,
    input  logic [2:0]  writenum,
    input  logic        write,
    input  logic [15:0] mdata,
    input  logic [15:0] sximm8,
    input  logic [8:0]  PC,
    input  logic [15:0] sximm5,
    output logic        Z,
    output logic        N,
    output logic        V,
    output logic [15:0] datapath_out
);

    logic [15:0] regs_q [8];
    logic [15:0] a_q, b_q, c_q;
    logic        z_q, n_q, v_q;

    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [15:0] shift_out;
    logic [15:0] ain, bin;
    logic [15:0] alu_res;
    logic        alu_ovf;

    // Write-back source; unrecognised select codes write zero.
    always_comb begin
        data_in = 16'h0000;
        case (vsel)
            4'b1000: data_in = mdata;
            4'b0100: data_in = sximm8;
            4'b0010: data_in = {7'b0, PC};
            4'b0001: data_in = c_q;
            default: data_in = 16'h0000;
        endcase
    end

    assign data_out = regs_q[readnum];

    always_comb begin
        shift_out = b_q;
        case (shift)
            2'b00: shift_out = b_q;
            2'b01: shift_out = {b_q[14:0], 1'b0};
            2'b10: shift_out = {1'b0, b_q[15:1]};
            2'b11: shift_out = {b_q[15], b_q[15:1]};
            default: shift_out = b_q;
        endcase
    end

    assign ain = asel ? 16'h0000 : a_q;
    assign bin = bsel ? sximm5 : shift_out;

    // Overflow: operands' effective signs agree but the result's sign differs.
    always_comb begin
        alu_res = 16'h0000;
        alu_ovf = 1'b0;
        case (ALUop)
            2'b00: begin
                alu_res = ain + bin;
                alu_ovf = (ain[15] == bin[15]) && (alu_res[15] != ain[15]);
            end
            2'b01: begin
                alu_res = ain - bin;
                alu_ovf = (ain[15] != bin[15]) && (alu_res[15] != ain[15]);
            end
            2'b10: alu_res = ain & bin;
            2'b11: alu_res = ~bin;
            default: alu_res = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
            a_q <= 16'h0000;
            b_q <= 16'h0000;
            c_q <= 16'h0000;
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            if (write) regs_q[writenum] <= data_in;
            if (loada) a_q <= data_out;
            if (loadb) b_q <= data_out;
            if (loadc) c_q <= alu_res;
            if (loads) begin
                z_q <= (alu_res == 16'h0000);
                n_q <= alu_res[15];
                v_q <= alu_ovf;
            end
        end
    end

    assign datapath_out = c_q;
    assign Z            = z_q;
    assign N            = n_q;
    assign V            = v_q;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed scenarios plus randomized strobes checked against an
// arithmetic reference model of the register file, operand registers and ALU.
module tb_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  readnum, writenum;
    logic [3:0]  vsel;
    logic        loada, loadb, loadc, loads, write;
    logic [1:0]  shift, ALUop;
    logic        asel, bsel;
    logic [15:0] mdata, sximm8, sximm5;
    logic [8:0]  PC;
    logic        Z, N, V;
    logic [15:0] datapath_out;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_r [8];
    logic [15:0] m_a, m_b, m_c;
    logic        m_z, m_n, m_v;

    always #5 clk = ~clk;

    datapath dut (
        .clk          (clk),
        .reset        (reset),
        .readnum      (readnum),
        .vsel         (vsel),
        .loada        (loada),
        .loadb        (loadb),
        .shift        (shift),
        .asel         (asel),
        .bsel         (bsel),
        .ALUop        (ALUop),
        .loadc        (loadc),
        .loads        (loads),
        .writenum     (writenum),
        .write        (write),
        .mdata        (mdata),
        .sximm8       (sximm8),
        .PC           (PC),
        .sximm5       (sximm5),
        .Z            (Z),
        .N            (N),
        .V            (V),
        .datapath_out (datapath_out)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_strobes();
        reset = 1'b0;
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        write = 1'b0;
    endtask

    // Reference model evaluated with integer arithmetic on the pre-edge state.
    task automatic tick();
        logic [15:0] dout, wb, sh, ain, bin, res;
        int sa, sb, s, bs;
        bit ovf;
        dout = m_r[readnum];
        case (vsel)
            4'b1000: wb = mdata;
            4'b0100: wb = sximm8;
            4'b0010: wb = 16'(PC);
            4'b0001: wb = m_c;
            default: wb = 16'h0000;
        endcase
        bs = int'($signed(m_b));
        case (shift)
            2'd0: sh = m_b;
            2'd1: sh = 16'(int'(m_b) * 2);
            2'd2: sh = 16'(int'(m_b) / 2);
            default: sh = 16'((bs - (bs & 1)) / 2);
        endcase
        ain = asel ? 16'h0000 : m_a;
        bin = bsel ? sximm5 : sh;
        sa = int'($signed(ain));
        sb = int'($signed(bin));
        ovf = 1'b0;
        case (ALUop)
            2'd0: begin s = sa + sb; res = 16'(s); ovf = (s > 32767) || (s < -32768); end
            2'd1: begin s = sa - sb; res = 16'(s); ovf = (s > 32767) || (s < -32768); end
            2'd2: res = ain & bin;
            default: res = ~bin;
        endcase
        @(posedge clk);
        #1;
        if (reset) begin
            for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
            m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
        end else begin
            if (write) m_r[writenum] = wb;
            if (loada) m_a = dout;
            if (loadb) m_b = dout;
            if (loadc) m_c = res;
            if (loads) begin
                m_z = (res == 16'h0000);
                m_n = ($signed(res) < 0);
                m_v = ovf;
            end
        end
        check_eq("model_out", datapath_out, m_c);
        check_eq("model_z", 16'(Z), 16'(m_z));
        check_eq("model_n", 16'(N), 16'(m_n));
        check_eq("model_v", 16'(V), 16'(m_v));
        clear_strobes();
    endtask

    task automatic set_reg(input logic [2:0] idx, input logic [15:0] val);
        vsel = 4'b0100; sximm8 = val; writenum = idx; write = 1'b1;
        tick();
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
        readnum = idx; loadb = 1'b1;
        tick();
        shift = 2'b00; asel = 1'b1; bsel = 1'b0; ALUop = 2'b00; loadc = 1'b1;
        tick();
        val = datapath_out;
    endtask

    task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
        set_reg(3'd6, a);
        set_reg(3'd7, b);
        readnum = 3'd6; loada = 1'b1;
        tick();
        readnum = 3'd7; loadb = 1'b1;
        tick();
        shift = 2'b00; asel = 1'b0; bsel = 1'b0;
    endtask

    initial begin
        logic [15:0] rv;
        clear_strobes();
        readnum = 0; writenum = 0; vsel = 4'b0001; shift = 0; ALUop = 0;
        asel = 0; bsel = 0; mdata = 0; sximm8 = 0; sximm5 = 0; PC = 0;
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
        m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
        reset = 1'b1;
        tick();
        check_eq("reset_out", datapath_out, 16'h0000);

        // Arbitrary loads, then reset with every strobe still asserted.
        set_reg(3'd4, 16'h1234);
        readnum = 3'd4; loada = 1; loadb = 1;
        tick();
        ALUop = 2'b11; loadc = 1; loads = 1; vsel = 4'b1000; mdata = 16'hBEEF; write = 1;
        tick();
        reset = 1; loada = 1; loadb = 1; loadc = 1; loads = 1; write = 1;
        tick();
        check_eq("rst_out", datapath_out, 16'h0000);
        check_eq("rst_znv", {13'b0, Z, N, V}, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), rv);
            check_eq($sformatf("rst_r%0d", i), rv, 16'h0000);
        end

        // MOV immediate into R0, then move through C.
        set_reg(3'd0, 16'h0007);
        read_reg(3'd0, rv);
        check_eq("mov_imm", rv, 16'h0007);

        // ADD R2 = R1 + (R0 << 1).
        set_reg(3'd1, 16'h0002);
        readnum = 3'd1; loada = 1;
        tick();
        readnum = 3'd0; loadb = 1;
        tick();
        shift = 2'b01; asel = 0; bsel = 0; ALUop = 2'b00; loadc = 1;
        tick();
        check_eq("add_shift", datapath_out, 16'd16);
        vsel = 4'b0001; writenum = 3'd2; write = 1;
        tick();
        read_reg(3'd2, rv);
        check_eq("add_wb_r2", rv, 16'd16);

        // CMP overflow and equality.
        load_ab(16'h7FFF, 16'hFFFF);
        ALUop = 2'b01; loads = 1;
        tick();
        check_eq("cmp_ovf_znv", {13'b0, Z, N, V}, 16'b011);
        load_ab(16'h0005, 16'h0005);
        ALUop = 2'b01; loads = 1;
        tick();
        check_eq("cmp_eq_znv", {13'b0, Z, N, V}, 16'b100);

        // MVN and AND; the prior overflow makes the AND clearing V observable.
        load_ab(16'h0000, 16'h00F0);
        ALUop = 2'b11; loadc = 1;
        tick();
        check_eq("mvn", datapath_out, 16'hFF0F);
        load_ab(16'h7FFF, 16'hFFFF);
        ALUop = 2'b01; loads = 1;
        tick();
        load_ab(16'h0FF0, 16'h00FF);
        ALUop = 2'b10; loadc = 1; loads = 1;
        tick();
        check_eq("and", datapath_out, 16'h00F0);
        check_eq("and_v", 16'(V), 16'h0000);

        // Address path with sximm5, then memory and PC write-back.
        load_ab(16'h0010, 16'h0000);
        bsel = 1; sximm5 = 16'hFFFF; ALUop = 2'b00; loadc = 1;
        tick();
        check_eq("addr_imm5", datapath_out, 16'h000F);
        bsel = 0;
        vsel = 4'b1000; mdata = 16'hABCD; writenum = 3'd5; write = 1;
        tick();
        read_reg(3'd5, rv);
        check_eq("mdata_r5", rv, 16'hABCD);
        vsel = 4'b0010; PC = 9'h1FF; writenum = 3'd3; write = 1;
        tick();
        read_reg(3'd3, rv);
        check_eq("pc_r3", rv, 16'h01FF);
        set_reg(3'd4, 16'h5A5A);
        vsel = 4'b0011; writenum = 3'd4; write = 1;
        tick();
        read_reg(3'd4, rv);
        check_eq("bad_vsel", rv, 16'h0000);

        // Randomized strobes against the model.
        for (int k = 0; k < 1500; k++) begin
            readnum  = 3'($urandom);
            writenum = 3'($urandom);
            shift    = 2'($urandom);
            ALUop    = 2'($urandom);
            asel     = ($urandom_range(0, 3) == 0);
            bsel     = ($urandom_range(0, 3) == 0);
            loada    = 1'($urandom);
            loadb    = 1'($urandom);
            loadc    = 1'($urandom);
            loads    = 1'($urandom);
            write    = 1'($urandom);
            reset    = ($urandom_range(0, 49) == 0);
            mdata    = 16'($urandom);
            rv       = 16'($urandom);
            sximm8   = {{8{rv[7]}}, rv[7:0]};
            sximm5   = {{11{rv[12]}}, rv[12:8]};
            PC       = 9'($urandom);
            if ($urandom_range(0, 3) == 0) vsel = 4'($urandom);
            else vsel = 4'b0001 << $urandom_range(0, 3);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
